mc_controller: RTL and testbench

//  Multi-cycle control unit. It drives the datapath control inputs:

---
 rtl/mc_controller_if.sv | 43 ++++
 rtl/mc_controller.sv | 176 +++++++++++++++++
 tb/tb_mc_controller.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/mc_controller_if.sv
// rtl/mc_controller_if.sv - control bus between mc_controller and the datapath; MC_CTRL_PERF_EN adds counters
interface mc_controller_if;
    logic [31:0] instruction;
    logic        ir_en;
    logic        pc_en;
    logic [1:0]  Wreg_sel;
    logic [1:0]  Wdata_sel;
    logic        W_en;
    logic [1:0]  ALUop;
    logic        ALUsrc;
    logic        DM_sel;
    logic        DM_en;
    logic        Branch;
    logic        EXT_sel;
    logic        Shift_sel;
    logic [2:0]  state;
`ifdef MC_CTRL_PERF_EN
    logic [31:0] cyc_cnt;
    logic [31:0] ret_cnt;

    modport master (
        input  instruction,
        output ir_en, pc_en, Wreg_sel, Wdata_sel, W_en, ALUop, ALUsrc,
               DM_sel, DM_en, Branch, EXT_sel, Shift_sel, state, cyc_cnt, ret_cnt
    );
    modport slave (
        output instruction,
        input  ir_en, pc_en, Wreg_sel, Wdata_sel, W_en, ALUop, ALUsrc,
               DM_sel, DM_en, Branch, EXT_sel, Shift_sel, state, cyc_cnt, ret_cnt
    );
`else
    modport master (
        input  instruction,
        output ir_en, pc_en, Wreg_sel, Wdata_sel, W_en, ALUop, ALUsrc,
               DM_sel, DM_en, Branch, EXT_sel, Shift_sel, state
    );
    modport slave (
        output instruction,
        input  ir_en, pc_en, Wreg_sel, Wdata_sel, W_en, ALUop, ALUsrc,
               DM_sel, DM_en, Branch, EXT_sel, Shift_sel, state
    );
`endif
endinterface

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multi-cycle FETCH/DEC/EXEC/MEM/WB control FSM; MC_CTRL_PERF_EN adds cyc_cnt/ret_cnt
module mc_controller #(
    parameter logic [5:0] OP_SPECIAL = 6'h00,
    parameter logic [5:0] FN_ADDU    = 6'h21,
    parameter logic [5:0] FN_SUBU    = 6'h23,
    parameter logic [5:0] OP_ORI     = 6'h0d,
    parameter logic [5:0] OP_LW      = 6'h23,
    parameter logic [5:0] OP_SW      = 6'h2b,
    parameter logic [5:0] OP_BEQ     = 6'h04,
    parameter logic [5:0] OP_LUI     = 6'h0f
) (
    input  logic              clk,
    input  logic              reset,
    mc_controller_if.master   bus
);
    typedef enum logic [2:0] {
        S_FETCH = 3'd0, S_DEC = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3, S_WB = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        C_NOP, C_ADDU, C_SUBU, C_ORI, C_LW, C_SW, C_BEQ, C_LUI
    } class_t;

    state_t state_q, state_d;
    class_t cls_q, cls_dec;

    logic       ir_en_c, pc_en_c, w_en_c, dm_en_c, branch_c, alusrc_c, ext_c, shift_c;
    logic [1:0] wreg_c, wdata_c, aluop_c;

    logic [5:0] opcode, funct;
    logic       unused_fields;
    assign opcode        = bus.instruction[31:26];
    assign funct         = bus.instruction[5:0];
    assign unused_fields = ^bus.instruction[25:6];

    always_comb begin
        cls_dec = C_NOP;
        case (opcode)
            OP_SPECIAL: begin
                if (funct == FN_ADDU)      cls_dec = C_ADDU;
                else if (funct == FN_SUBU) cls_dec = C_SUBU;
            end
            OP_ORI:  cls_dec = C_ORI;
            OP_LW:   cls_dec = C_LW;
            OP_SW:   cls_dec = C_SW;
            OP_BEQ:  cls_dec = C_BEQ;
            OP_LUI:  cls_dec = C_LUI;
            default: cls_dec = C_NOP;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            cls_q   <= C_NOP;
        end else begin
            state_q <= state_d;
            if (state_q == S_DEC) cls_q <= cls_dec;
        end
    end

    always_comb begin
        state_d  = S_FETCH;
        ir_en_c  = 1'b0;
        pc_en_c  = 1'b0;
        w_en_c   = 1'b0;
        dm_en_c  = 1'b0;
        branch_c = 1'b0;
        alusrc_c = 1'b0;
        ext_c    = 1'b0;
        shift_c  = 1'b0;
        wreg_c   = 2'd0;
        wdata_c  = 2'd0;
        aluop_c  = 2'd0;
        case (state_q)
            S_FETCH: begin
                ir_en_c = 1'b1;
                state_d = S_DEC;
            end
            // The class register only loads at the end of DEC, so a NOP's
            // retirement strobe is the one output taken from the live decode.
            S_DEC: begin
                if (cls_dec == C_NOP) begin
                    pc_en_c = 1'b1;
                    state_d = S_FETCH;
                end else if (cls_dec == C_LUI) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (cls_q)
                    C_ADDU, C_SUBU, C_ORI: state_d = S_WB;
                    C_LW, C_SW:            state_d = S_MEM;
                    C_BEQ: begin
                        branch_c = 1'b1;
                        pc_en_c  = 1'b1;
                        state_d  = S_FETCH;
                    end
                    default:               state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (cls_q == C_LW) begin
                    state_d = S_WB;
                end else begin
                    dm_en_c = 1'b1;
                    pc_en_c = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_WB: begin
                w_en_c  = 1'b1;
                pc_en_c = 1'b1;
                wreg_c  = (cls_q == C_ADDU || cls_q == C_SUBU) ? 2'd1 : 2'd0;
                wdata_c = (cls_q == C_LW) ? 2'd1 : (cls_q == C_LUI) ? 2'd2 : 2'd0;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // Datapath mux selects stay stable from EXEC to the last cycle.
        if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
            case (cls_q)
                C_SUBU: aluop_c = 2'd1;
                C_ORI: begin
                    aluop_c  = 2'd2;
                    alusrc_c = 1'b1;
                end
                C_LW, C_SW: begin
                    alusrc_c = 1'b1;
                    ext_c    = 1'b1;
                end
                C_BEQ: begin
                    aluop_c = 2'd1;
                    ext_c   = 1'b1;
                end
                C_LUI:   shift_c = 1'b1;
                default: aluop_c = 2'd0;
            endcase
        end
    end

    // Reset forces every output low immediately, not at the next edge.
    assign bus.ir_en     = reset & ir_en_c;
    assign bus.pc_en     = reset & pc_en_c;
    assign bus.W_en      = reset & w_en_c;
    assign bus.DM_en     = reset & dm_en_c;
    assign bus.Branch    = reset & branch_c;
    assign bus.ALUsrc    = reset & alusrc_c;
    assign bus.EXT_sel   = reset & ext_c;
    assign bus.Shift_sel = reset & shift_c;
    assign bus.DM_sel    = 1'b0;
    assign bus.Wreg_sel  = reset ? wreg_c  : 2'd0;
    assign bus.Wdata_sel = reset ? wdata_c : 2'd0;
    assign bus.ALUop     = reset ? aluop_c : 2'd0;
    assign bus.state     = reset ? 3'(state_q) : 3'd0;

`ifdef MC_CTRL_PERF_EN
    logic [31:0] cyc_q, ret_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc_q <= 32'd0;
            ret_q <= 32'd0;
        end else begin
            cyc_q <= cyc_q + 32'd1;
            if (pc_en_c) ret_q <= ret_q + 32'd1;
        end
    end

    assign bus.cyc_cnt = cyc_q;
    assign bus.ret_cnt = ret_q;
`endif
endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - scoreboard bench for mc_controller with randomized instruction stream
module tb_mc_controller;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mc_controller_if bus();

    mc_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef enum int { K_NOP, K_ADDU, K_SUBU, K_ORI, K_LW, K_SW, K_BEQ, K_LUI } kind_t;

    typedef struct {
        logic [17:0] v;
        logic [31:0] cyc;
        logic [31:0] ret;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_cyc = 0;
    logic [31:0] exp_ret = 0;

    function automatic kind_t classify(input logic [31:0] w);
        case (w[31:26])
            6'h00:   return (w[5:0] == 6'h21) ? K_ADDU : (w[5:0] == 6'h23) ? K_SUBU : K_NOP;
            6'h0d:   return K_ORI;
            6'h23:   return K_LW;
            6'h2b:   return K_SW;
            6'h04:   return K_BEQ;
            6'h0f:   return K_LUI;
            default: return K_NOP;
        endcase
    endfunction

    function automatic int latency(input kind_t k);
        case (k)
            K_LW:         return 5;
            K_BEQ, K_LUI: return 3;
            K_NOP:        return 2;
            default:      return 4;
        endcase
    endfunction

    // Cycle i (1-based) of an n-cycle instruction of kind k, as the packed output vector.
    function automatic logic [17:0] expect_vec(input kind_t k, input int i, input int n);
        logic       last, hold, writes;
        logic [1:0] aluop, wreg, wdata;
        logic [2:0] st;
        last   = (i == n);
        hold   = (i >= 3);
        writes = (k == K_ADDU || k == K_SUBU || k == K_ORI || k == K_LW || k == K_LUI);
        if (i == 1)                                 st = 3'd0;
        else if (i == 2)                            st = 3'd1;
        else if (last && k != K_SW && k != K_BEQ)   st = 3'd4;
        else if (i == 3)                            st = 3'd2;
        else                                        st = 3'd3;
        aluop = !hold ? 2'd0 : (k == K_SUBU || k == K_BEQ) ? 2'd1 : (k == K_ORI) ? 2'd2 : 2'd0;
        wreg  = (last && (k == K_ADDU || k == K_SUBU)) ? 2'd1 : 2'd0;
        wdata = !last ? 2'd0 : (k == K_LW) ? 2'd1 : (k == K_LUI) ? 2'd2 : 2'd0;
        return {i == 1, last, wreg, wdata, last && writes, aluop,
                hold && (k == K_ORI || k == K_LW || k == K_SW), 1'b0,
                last && k == K_SW, last && k == K_BEQ,
                hold && (k == K_LW || k == K_SW || k == K_BEQ),
                hold && k == K_LUI, st};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [17:0] v);
        exp_t e;
        e.v = v;
        e.cyc = exp_cyc;
        e.ret = exp_ret;
        sb.push_back(e);
        exp_cyc = exp_cyc + 1;
        if (v[16]) exp_ret = exp_ret + 1;
    endtask

    task automatic push_reset();
        exp_t e;
        e.v = '0;
        e.cyc = 0;
        e.ret = 0;
        sb.push_back(e);
        exp_cyc = 0;
        exp_ret = 0;
    endtask

    task automatic issue(input logic [31:0] w);
        kind_t k;
        int    n;
        k = classify(w);
        n = latency(k);
        bus.instruction = w;
        for (int i = 1; i <= n; i++) push_exp(expect_vec(k, i, n));
        repeat (n) next_cycle();
    endtask

    function automatic logic [17:0] actual_vec();
        return {bus.ir_en, bus.pc_en, bus.Wreg_sel, bus.Wdata_sel, bus.W_en, bus.ALUop,
                bus.ALUsrc, bus.DM_sel, bus.DM_en, bus.Branch, bus.EXT_sel, bus.Shift_sel,
                bus.state};
    endfunction

    // Monitor: every cycle with a pending expectation is compared mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (actual_vec() !== e.v) begin
                errors++;
                $display("FAIL outputs t=%0t instr=%h got=%h want=%h", $time, bus.instruction, actual_vec(), e.v);
            end
`ifdef MC_CTRL_PERF_EN
            checks++;
            if (bus.cyc_cnt !== e.cyc || bus.ret_cnt !== e.ret) begin
                errors++;
                $display("FAIL perf t=%0t got cyc=%0d ret=%0d want cyc=%0d ret=%0d",
                         $time, bus.cyc_cnt, bus.ret_cnt, e.cyc, e.ret);
            end
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired got=running want=finished");
        $fatal(1);
    end

    initial begin
        logic [31:0] rnd;
        logic [31:0] w;
        bus.instruction = 32'h0;

        repeat (3) begin
            next_cycle();
            push_reset();
        end
        next_cycle();
        reset = 1'b1;

        issue(32'h00221821);
        issue(32'h8c220004);
        issue(32'hac220004);
        issue(32'h10220003);
        issue(32'h3c011234);
        issue(32'hfc000000);
        issue(32'h00221823);
        issue(32'h3422ffff);
        issue(32'h00221822);

        // Abort an lw in MEM: outputs must drop within the cycle, no write follows.
        bus.instruction = 32'h8c220004;
        for (int i = 1; i <= 3; i++) push_exp(expect_vec(K_LW, i, 5));
        repeat (3) next_cycle();
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (actual_vec() !== 18'h0) begin
            errors++;
            $display("FAIL async_reset got=%h want=%h", actual_vec(), 18'h0);
        end
`ifdef MC_CTRL_PERF_EN
        checks++;
        if (bus.ret_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_ret_cnt got=%0d want=0", bus.ret_cnt);
        end
`endif
        push_reset();
        repeat (2) begin
            next_cycle();
            push_reset();
        end
        next_cycle();
        reset = 1'b1;

        for (int n = 0; n < 80; n++) begin
            rnd = $urandom;
            case ($urandom_range(0, 7))
                0:       w = {6'h00, rnd[25:6], 6'h21};
                1:       w = {6'h00, rnd[25:6], 6'h23};
                2:       w = {6'h0d, rnd[25:0]};
                3:       w = {6'h23, rnd[25:0]};
                4:       w = {6'h2b, rnd[25:0]};
                5:       w = {6'h04, rnd[25:0]};
                6:       w = {6'h0f, rnd[25:0]};
                default: w = rnd;
            endcase
            issue(w);
        end

        next_cycle();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
